imem_sync_fetch: RTL and testbench

Parametrised synchronous-read instruction memory for the RISC-V pipeline's IF stage. Serves one 32-bit little-endian instruction per accepted fetch request. Read latency is configurable at 1 or 2 cycles. Supports stall and flush from the hazard unit, flags misaligned and out-of-range fetches, and has a word-wide program-load port for bench and boot loading.

---
 rtl/imem_sync_fetch.sv | 96 +++++++++
 tb/tb_imem_sync_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync_fetch.sv
// Synchronous-read instruction memory for the IF stage: one 32-bit little-endian word per accepted
// fetch, 1- or 2-stage read pipeline with stall/flush, fault flagging and a word-wide load port.
module imem_sync_fetch #(
    parameter int          ADDR_WIDTH   = 64,
    parameter int          DEPTH_BYTES  = 256,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_INST     = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  inst_valid,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  fault,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [31:0]           prog_data
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(DEPTH_BYTES - 4);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic                  fault;
    } stage_t;

    localparam stage_t EMPTY_STAGE = '{valid: 1'b0, addr: '0, data: NOP_INST, fault: 1'b0};

    // Byte storage grouped four bytes per word, lowest address in bits [7:0]; every access is
    // word-aligned, so the word view is exactly the little-endian byte array.
    logic [31:0] memQ [WORDS] = '{default: NOP_INST};

    logic             fetchAccept;
    logic             fetchFault;
    logic             progOk;
    logic [IDX_W-1:0] fetchIdx;
    logic [IDX_W-1:0] progIdx;
    stage_t           stageInD;
    stage_t           stageQ [READ_LATENCY];

    // Range checks use the full address width so huge addresses never alias into the array.
    assign fetchAccept = fetch_req && !stall;
    assign fetchFault  = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD_ADDR);
    assign fetchIdx    = fetch_addr[IDX_W+1:2];
    assign progOk      = (prog_addr[1:0] == 2'b00) && (prog_addr <= LAST_WORD_ADDR);
    assign progIdx     = prog_addr[IDX_W+1:2];

    always_comb begin
        stageInD = EMPTY_STAGE;
        if (fetchAccept) begin
            stageInD.valid = 1'b1;
            stageInD.addr  = fetch_addr;
            stageInD.fault = fetchFault;
            stageInD.data  = fetchFault ? NOP_INST : memQ[fetchIdx];
        end
    end

    // Stage 1 samples the pre-edge array contents, which gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stageQ[i] <= EMPTY_STAGE;
            end
        end else if (flush) begin
            stageQ[0] <= stageInD;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stageQ[i] <= EMPTY_STAGE;
            end
        end else if (!stall) begin
            stageQ[0] <= stageInD;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stageQ[i] <= stageQ[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && progOk) begin
            memQ[progIdx] <= prog_data;
        end
    end

    assign inst_valid  = stageQ[READ_LATENCY-1].valid;
    assign instruction = stageQ[READ_LATENCY-1].data;
    assign inst_addr   = stageQ[READ_LATENCY-1].addr;
    assign fault       = stageQ[READ_LATENCY-1].fault;

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Drives a latency-1 and a latency-2 instance with identical stimulus; a queue-based scoreboard
// holds the expected result of every accepted fetch and compares it on the cycle it is due.
module tb_imem_sync_fetch;

    localparam int          AW  = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          stall;
        logic          flush;
        logic          rst;
        logic          we;
        logic [AW-1:0] pAddr;
        logic [31:0]   pData;
        logic [31:0]   expInst;
        logic          expFault;
    } stim_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   inst;
        logic          fault;
        int            accEdge;
        int            stallsAtAcc;
    } sb_t;

    typedef struct {
        logic          valid;
        logic [31:0]   inst;
        logic [AW-1:0] addr;
        logic          fault;
        logic          checkAddr;
    } out_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetchReq;
    logic [AW-1:0] fetchAddr;
    logic          stall;
    logic          flush;
    logic          progWe;
    logic [AW-1:0] progAddr;
    logic [31:0]   progData;

    logic [1:0]    instValid;
    logic [31:0]   instruction [2];
    logic [AW-1:0] instAddr [2];
    logic [1:0]    fault;

    always #5 clk = ~clk;

    imem_sync_fetch #(.ADDR_WIDTH(AW), .DEPTH_BYTES(256), .READ_LATENCY(1), .NOP_INST(NOP)) dutL1 (
        .clk(clk), .reset(reset), .fetch_req(fetchReq), .fetch_addr(fetchAddr),
        .stall(stall), .flush(flush), .inst_valid(instValid[0]), .instruction(instruction[0]),
        .inst_addr(instAddr[0]), .fault(fault[0]), .prog_we(progWe), .prog_addr(progAddr),
        .prog_data(progData)
    );

    imem_sync_fetch #(.ADDR_WIDTH(AW), .DEPTH_BYTES(256), .READ_LATENCY(2), .NOP_INST(NOP)) dutL2 (
        .clk(clk), .reset(reset), .fetch_req(fetchReq), .fetch_addr(fetchAddr),
        .stall(stall), .flush(flush), .inst_valid(instValid[1]), .instruction(instruction[1]),
        .inst_addr(instAddr[1]), .fault(fault[1]), .prog_we(progWe), .prog_addr(progAddr),
        .prog_data(progData)
    );

    sb_t  sbq0[$];
    sb_t  sbq1[$];
    out_t prevExp [2];
    int   cycleNum    = 0;
    int   stallEdges  = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic lastReset   = 1'b0;
    logic lastFlush   = 1'b0;
    logic lastStall   = 1'b0;

    function automatic stim_t idleS();
        stim_t s;
        s.req = 1'b0; s.addr = '0; s.stall = 1'b0; s.flush = 1'b0; s.rst = 1'b0;
        s.we = 1'b0; s.pAddr = '0; s.pData = '0; s.expInst = NOP; s.expFault = 1'b0;
        return s;
    endfunction

    function automatic stim_t fetchS(input logic [AW-1:0] a, input logic [31:0] inst, input logic flt);
        stim_t s = idleS();
        s.req = 1'b1; s.addr = a; s.expInst = inst; s.expFault = flt;
        return s;
    endfunction

    function automatic stim_t writeS(input logic [AW-1:0] a, input logic [31:0] d);
        stim_t s = idleS();
        s.we = 1'b1; s.pAddr = a; s.pData = d;
        return s;
    endfunction

    task automatic pushAll(input stim_t s);
        sb_t e;
        e.addr = s.addr; e.inst = s.expInst; e.fault = s.expFault;
        e.accEdge = cycleNum; e.stallsAtAcc = stallEdges;
        sbq0.push_back(e);
        sbq1.push_back(e);
    endtask

    task automatic checkOutput(input int k);
        out_t exp;
        sb_t  head;
        logic haveHead;
        int   due;
        logic bad;
        exp = '{valid: 1'b0, inst: NOP, addr: '0, fault: 1'b0, checkAddr: 1'b0};
        haveHead = 1'b0;
        head = '{addr: '0, inst: '0, fault: 1'b0, accEdge: 0, stallsAtAcc: 0};
        if (k == 0 && sbq0.size() > 0) begin
            head = sbq0[0]; haveHead = 1'b1;
        end else if (k == 1 && sbq1.size() > 0) begin
            head = sbq1[0]; haveHead = 1'b1;
        end
        due = haveHead ? head.accEdge + k + (stallEdges - head.stallsAtAcc) : -1;
        if (lastReset) begin
            exp.checkAddr = 1'b1;
        end else if (haveHead && due == cycleNum) begin
            exp = '{valid: 1'b1, inst: head.inst, addr: head.addr, fault: head.fault, checkAddr: 1'b1};
            if (k == 0) void'(sbq0.pop_front());
            else        void'(sbq1.pop_front());
        end else if (lastStall && !lastFlush) begin
            exp = prevExp[k];
        end
        prevExp[k] = exp;
        bad = (instValid[k] !== exp.valid) || (instruction[k] !== exp.inst) ||
              (fault[k] !== exp.fault) || (exp.checkAddr && (instAddr[k] !== exp.addr));
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL outL%0d cycle %0d: got v=%0b inst=%h addr=%h f=%0b, expected v=%0b inst=%h addr=%h f=%0b",
                     k + 1, cycleNum, instValid[k], instruction[k], instAddr[k], fault[k],
                     exp.valid, exp.inst, exp.addr, exp.fault);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        reset = s.rst; fetchReq = s.req; fetchAddr = s.addr; stall = s.stall; flush = s.flush;
        progWe = s.we; progAddr = s.pAddr; progData = s.pData;
        @(posedge clk);
        cycleNum++;
        lastReset = s.rst; lastFlush = s.flush; lastStall = s.stall;
        if (s.rst) begin
            sbq0.delete(); sbq1.delete();
        end else if (s.flush) begin
            sbq0.delete(); sbq1.delete();
            if (s.req && !s.stall) pushAll(s);
        end else if (s.stall) begin
            stallEdges++;
        end else if (s.req) begin
            pushAll(s);
        end
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
    endtask

    initial begin
        stim_t vecs[$];
        stim_t s;

        s = idleS(); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        applyStimulus(writeS(64'h0, 32'h10000513));
        applyStimulus(writeS(64'h4, 32'h00500293));
        applyStimulus(writeS(64'h8, 32'h00000b13));

        // Streaming, then faults and range boundaries.
        vecs.push_back(fetchS(64'h0, 32'h10000513, 1'b0));
        vecs.push_back(fetchS(64'h4, 32'h00500293, 1'b0));
        vecs.push_back(fetchS(64'h8, 32'h00000b13, 1'b0));
        vecs.push_back(idleS());
        vecs.push_back(idleS());
        vecs.push_back(fetchS(64'h2, NOP, 1'b1));
        vecs.push_back(fetchS(64'h100, NOP, 1'b1));
        vecs.push_back(fetchS(64'h0, 32'h10000513, 1'b0));
        vecs.push_back(fetchS(64'hFC, NOP, 1'b0));
        vecs.push_back(fetchS(64'h8000_0000_0000_0000, NOP, 1'b1));
        vecs.push_back(fetchS(64'h0000_0001_0000_0000, NOP, 1'b1));
        vecs.push_back(idleS());
        vecs.push_back(idleS());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Stall for three cycles with the next request held; a write lands during the stall.
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        applyStimulus(fetchS(64'h4, 32'h00500293, 1'b0));
        s = fetchS(64'h8, 32'h00000b13, 1'b0); s.stall = 1'b1;
        s.we = 1'b1; s.pAddr = 64'h10; s.pData = 32'h00c00113;
        applyStimulus(s);
        s.we = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        s.stall = 1'b0;
        applyStimulus(s);
        applyStimulus(idleS());
        applyStimulus(idleS());

        // Flush with a redirect to 0x8, then flush together with stall.
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        applyStimulus(fetchS(64'h4, 32'h00500293, 1'b0));
        s = fetchS(64'h8, 32'h00000b13, 1'b0); s.flush = 1'b1;
        applyStimulus(s);
        applyStimulus(idleS());
        applyStimulus(idleS());
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        s = fetchS(64'h4, 32'h00500293, 1'b0); s.flush = 1'b1; s.stall = 1'b1;
        applyStimulus(s);
        applyStimulus(idleS());
        applyStimulus(idleS());

        // Read-before-write collision and filtered writes.
        s = fetchS(64'h4, 32'h00500293, 1'b0);
        s.we = 1'b1; s.pAddr = 64'h4; s.pData = 32'h008000ef;
        applyStimulus(s);
        applyStimulus(fetchS(64'h4, 32'h008000ef, 1'b0));
        applyStimulus(writeS(64'h6, 32'hdeadbeef));
        applyStimulus(writeS(64'h0000_0001_0000_0000, 32'hdeadbeef));
        applyStimulus(writeS(64'h100, 32'hdeadbeef));
        applyStimulus(fetchS(64'h4, 32'h008000ef, 1'b0));
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        applyStimulus(fetchS(64'h8, 32'h00000b13, 1'b0));
        applyStimulus(fetchS(64'h10, 32'h00c00113, 1'b0));
        applyStimulus(idleS());
        applyStimulus(idleS());

        // Reset mid-stream with stall high and a write in the reset cycle.
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        s = fetchS(64'h4, 32'h008000ef, 1'b0); s.rst = 1'b1; s.stall = 1'b1;
        s.we = 1'b1; s.pAddr = 64'hC; s.pData = 32'h00a00093;
        applyStimulus(s);
        applyStimulus(fetchS(64'h8, 32'h00000b13, 1'b0));
        applyStimulus(fetchS(64'h0, 32'h10000513, 1'b0));
        applyStimulus(fetchS(64'h4, 32'h008000ef, 1'b0));
        applyStimulus(fetchS(64'hC, 32'h00a00093, 1'b0));
        applyStimulus(idleS());
        applyStimulus(idleS());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
